// File: rtl/aes128_pkg.sv
// Shared definitions for the AES-128 inverse key schedule.
//   aes_ks_state_e : FSM state encoding (IDLE, FWD, REV)
//   AES_NR, AES_NK : AES-128 geometry
//   aes_rcon()     : round constant table, Rcon[1..10]
//   gf_mul()       : GF(2^8) multiply modulo x^8+x^4+x^3+x+1
package aes128_pkg;

  localparam int AES_NR = 10;
  localparam int AES_NK = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2
  } aes_ks_state_e;

  // Round constant for round r; rounds outside 1..10 yield 0.
  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Shift-and-add multiply with reduction after every doubling.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational.
//   data : input byte
//   sub  : substituted byte
// The multiplicative inverse is formed as data^254 by a fixed
// square-and-multiply chain (0 maps to 0 naturally), followed by the
// FIPS-197 affine transform.
module aes_sbox
  import aes128_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  always_comb begin
    x2   = gf_mul(data, data);
    x3   = gf_mul(x2, data);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
  end

  // b = inv ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63
  assign sub = inv
             ^ {inv[6:0], inv[7]}
             ^ {inv[5:0], inv[7:6]}
             ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]}
             ^ 8'h63;

endmodule

// File: rtl/aes128_inv_key_sched.sv
// AES-128 key schedule that delivers round keys in decryption order.
//   clk, reset  : clock, asynchronous active-low reset
//   start       : load cipher_key and begin (sampled in IDLE only)
//   cipher_key  : 128-bit key, w0 = [127:96]
//   busy        : FSM not in IDLE
//   rk_valid    : round_key/rk_index valid (held in REV)
//   rk_ready    : consumer accept
//   rk_index    : round number of round_key, 10 down to 0
//   round_key   : current round key
//   done        : one-cycle pulse after key 0 is accepted
// Handshake: a key transfers on every rising edge where rk_valid and
// rk_ready are both high; while rk_valid is high and rk_ready low,
// round_key and rk_index hold.
// FWD runs the forward recurrence up to key 10; REV walks it back one
// key per accepted transfer. A single key register and a single
// SubWord datapath serve both directions.
module aes128_inv_key_sched
  import aes128_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipher_key,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [3:0]   rk_index,
  output logic [127:0] round_key,
  output logic         done
);

  localparam logic [3:0] LAST_FWD = 4'(AES_NR - 1);

  aes_ks_state_e state_q, state_d;
  logic [127:0]  key_q, key_d;
  logic [3:0]    rnd_q, rnd_d;
  logic          done_q, done_d;

  logic [31:0]  w0, w1, w2, w3, rec_w3, rot_src, rot_w, sub_w, t_w;
  logic [3:0]   rc_idx;
  logic [127:0] fwd_key, inv_key, step_key;
  logic         is_rev;

  assign {w0, w1, w2, w3} = key_q;
  assign is_rev = (state_q == ST_REV);

  // In REV the word fed to SubWord is the recovered w3 of the previous
  // key, which is w3'^w2' of the current one.
  assign rec_w3  = w3 ^ w2;
  assign rot_src = is_rev ? rec_w3 : w3;
  assign rot_w   = {rot_src[23:0], rot_src[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .data (rot_w[8*i +: 8]),
      .sub  (sub_w[8*i +: 8])
    );
  end

  // FWD builds key rnd_q+1; REV undoes key rnd_q.
  assign rc_idx = is_rev ? rnd_q : rnd_q + 4'd1;
  assign t_w    = sub_w ^ {aes_rcon(rc_idx), 24'h0};

  always_comb begin
    fwd_key[127:96] = w0 ^ t_w;
    fwd_key[95:64]  = w1 ^ fwd_key[127:96];
    fwd_key[63:32]  = w2 ^ fwd_key[95:64];
    fwd_key[31:0]   = w3 ^ fwd_key[63:32];
    inv_key         = {w0 ^ t_w, w1 ^ w0, w2 ^ w1, rec_w3};
  end

  assign step_key = is_rev ? inv_key : fwd_key;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = cipher_key;
          rnd_d   = 4'd0;
          state_d = ST_FWD;
        end
      end
      ST_FWD: begin
        key_d = step_key;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == LAST_FWD) state_d = ST_REV;
      end
      ST_REV: begin
        if (rk_ready) begin
          if (rnd_q == 4'd0) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = step_key;
            rnd_d = rnd_q - 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign rk_valid  = is_rev;
  assign rk_index  = rnd_q;
  assign round_key = key_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes128_inv_key_sched.sv
// Self-checking bench for aes128_inv_key_sched. The reference expands
// the key with the textbook word recurrence over w[0..43], using an
// S-box built by brute-force inverse search, and queues the expected
// (index, key) pairs in decryption order.
module tb_aes128_inv_key_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipher_key;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [3:0]   rk_index;
  logic [127:0] round_key;
  logic         done;

  aes128_inv_key_sched dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cipher_key (cipher_key),
    .busy       (busy),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .rk_index   (rk_index),
    .round_key  (round_key),
    .done       (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [131:0] exp_q[$];
  logic [127:0] ref_rk [0:10];
  logic [127:0] got_rk [0:10];
  logic [7:0]   sbox_tab [0:255];

  task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_tab[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t ^= {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver ----------------
  // Called at a falling edge in IDLE. rand_rdy randomises rk_ready,
  // inject drives stray starts during FWD/REV, and abort_at asserts
  // reset once the key of that index is presented (15 = never).
  task automatic run_seq(input logic [127:0] key, input bit rand_rdy,
                         input bit inject, input int abort_at);
    int budget;
    expand(key);
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), ref_rk[r]});
    start = 1'b1;
    cipher_key = key;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_fwd", busy, 1);
    for (int c = 1; c <= 9; c++) begin
      if (inject && c == 4) begin
        start = 1'b1;
        cipher_key = rand_key();
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    check("latency_early", rk_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("latency", rk_valid, 1);
    budget = 0;
    while (exp_q.size() > 0 && budget < 400) begin
      budget++;
      if (int'(exp_q[0][131:128]) == abort_at) begin
        rk_ready = 1'b0;
        start = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("rst_key", round_key, 0);
        check("rst_idx", rk_index, 0);
        check("rst_valid", rk_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1 check("rst_hold_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_wait_start", busy, 0);
        return;
      end
      rk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject) begin
        start = 1'($urandom_range(0, 1));
        cipher_key = rand_key();
      end
      check("rk_valid", rk_valid, 1);
      check("rk", {rk_index, round_key}, exp_q[0]);
      if (rk_ready && rk_index <= 4'd10) got_rk[rk_index] = round_key;
      @(posedge clk);
      if (rk_ready) void'(exp_q.pop_front());
      @(negedge clk);
    end
    start = 1'b0;
    rk_ready = 1'b0;
    check("timeout", 132'(exp_q.size()), 0);
    check("done_pulse", done, 1);
    check("done_busy", busy, 0);
    check("done_valid", rk_valid, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k;
    reset = 1'b0;
    start = 1'b0;
    rk_ready = 1'b0;
    cipher_key = '0;
    build_sbox();
    #12;
    check("reset_key", round_key, 0);
    check("reset_idx", rk_index, 0);
    check("reset_valid", rk_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // FIPS-197 vector, always ready
    run_seq(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0, 1'b0, 15);
    check("fips_k10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("fips_k9",  got_rk[9],  128'hac7766f319fadc2128d12941575c006e);
    check("fips_k1",  got_rk[1],  128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_k0",  got_rk[0],  128'h2b7e151628aed2a6abf7158809cf4f3c);
    @(negedge clk);
    check("done_drop", done, 0);
    check("idle_hold", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("idle_valid", rk_valid, 0);

    // backpressure
    run_seq(rand_key(), 1'b1, 1'b0, 15);
    @(negedge clk);
    // stray starts during FWD and REV
    run_seq(rand_key(), 1'b1, 1'b1, 15);
    @(negedge clk);
    // reset mid-REV, then a fresh full run
    run_seq(rand_key(), 1'b1, 1'b0, 5);
    run_seq(rand_key(), 1'b1, 1'b0, 15);
    // back-to-back with all-zero key
    run_seq(128'h0, 1'b1, 1'b0, 15);
    check("zero_k10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    // more random keys back-to-back
    for (int n = 0; n < 4; n++) begin
      k = rand_key();
      run_seq(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 15);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
